// File: rtl/wishbone_uart_rx.sv
// wishbone_uart_rx: 8N1 serial receiver with a Wishbone classic slave port.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO;
// otherwise a single holding register with a valid flag stores the byte.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   ser_rx              asynchronous serial input, idle high
//   wishbone_*_i        slave request (addr bit [2] selects data/status)
//   wishbone_data_o     read data, zero whenever ack is low
//   wishbone_ack_o      one-cycle acknowledge per request
//   rx_irq_o            high while at least one received byte is held
//
// Registers:
//   0x0 read : {24'b0, oldest byte}, popped on the ack cycle (0 if empty)
//   0x4 read : {29'b0, frame_err, overrun, valid}
//   0x4 write: bit1 clears overrun, bit2 clears frame_err
module wishbone_uart_rx #(
    parameter int BIT_CYCLES = 262,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ser_rx,
    input  logic [31:0] wishbone_addr_i,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_we_i,
    input  logic [3:0]  wishbone_sel_i,
    input  logic        wishbone_stb_i,
    input  logic        wishbone_cyc_i,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_ack_o,
    output logic        rx_irq_o
);

    localparam int DIV_W = 10;
    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(BIT_CYCLES);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BIT_CYCLES / 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detect
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, rx_prev_q;
    logic rx_fall;

    assign rx_fall = rx_prev_q & ~sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= ser_rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             div_expire;
    logic             push;
    logic             frame_set;

    // The divider counts down; the sample is taken on the cycle it reads 1,
    // so a load of N places the sample N clocks after the load.
    assign div_expire = (div_q == DIV_W'(1));

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d   = START;
                    div_d     = DIV_HALF;
                    bit_cnt_d = 3'd0;
                end
            end
            START: begin
                if (div_expire) begin
                    if (!sync2_q) begin
                        state_d = DATA;
                        div_d   = DIV_FULL;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (div_expire) begin
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    div_d     = DIV_FULL;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (div_expire) begin
                    push      = sync2_q;
                    frame_set = ~sync2_q;
                    state_d   = IDLE;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Wishbone handshake and register decode
    // ------------------------------------------------------------------
    logic ack_q, ack_d;
    logic xfer, rd_en, wr_en_bus, sel_status;
    logic pop;
    logic empty, full;
    logic [7:0] head;

    // A held request is answered once; ack low for a cycle separates
    // back-to-back requests.
    assign ack_d      = wishbone_cyc_i & wishbone_stb_i & ~ack_q;
    assign xfer       = ack_q & wishbone_cyc_i & wishbone_stb_i;
    assign rd_en      = xfer & ~wishbone_we_i;
    assign wr_en_bus  = xfer & wishbone_we_i;
    assign sel_status = wishbone_addr_i[2];
    assign pop        = rd_en & ~sel_status & ~empty;

    // ------------------------------------------------------------------
    // Error flags
    // ------------------------------------------------------------------
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;
    logic ovr_set, clr_ovr, clr_fe;

    // A pop in the same cycle frees the slot, so it is not an overrun.
    assign ovr_set = push & full & ~pop;
    assign clr_ovr = wr_en_bus & sel_status & wishbone_data_i[1];
    assign clr_fe  = wr_en_bus & sel_status & wishbone_data_i[2];

    always_comb begin
        overrun_d   = ovr_set | (overrun_q & ~clr_ovr);
        frame_err_d = frame_set | (frame_err_q & ~clr_fe);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive storage
    // ------------------------------------------------------------------
    logic store_en;

    assign store_en = push & (~full | pop);

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store_en) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({store_en, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [7:0]  hold_q, hold_d;
    logic        valid_q, valid_d;
    logic [31:0] unused_depth;

    assign unused_depth = 32'(FIFO_DEPTH);

    assign empty = ~valid_q;
    assign full  = valid_q;
    assign head  = hold_q;

    always_comb begin
        hold_d  = store_en ? shift_q : hold_q;
        valid_d = store_en | (valid_q & ~pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        wishbone_data_o = '0;
        if (rd_en) begin
            if (sel_status) begin
                wishbone_data_o = {29'b0, frame_err_q, overrun_q, ~empty};
            end else if (!empty) begin
                wishbone_data_o = {24'b0, head};
            end
        end
    end

    assign wishbone_ack_o = ack_q;
    assign rx_irq_o       = ~empty;

    logic unused_bits;
    assign unused_bits = ^{wishbone_sel_i, wishbone_addr_i[31:3],
                           wishbone_addr_i[1:0], wishbone_data_i[31:3],
                           wishbone_data_i[0]};

endmodule
